cmov_operand_scoreboard: RTL and testbench

- ID-stage consumer of the conditional-move write decision.
- Tracks in-flight destination registers through EX/MEM/WB.
- Resolves whether a MOVZ/MOVN-style op actually writes, using the same rule as the MEM-stage write enable: `(RegWrite & ~CondMov) | (CondMov & Zero)`.
- Tells ID whether each source operand must stall, come from the register file, or be forwarded from MEM or WB.

---
 rtl/cmov_pkg.sv | 32 +++
 rtl/cmov_fwd_select.sv | 33 +++
 rtl/cmov_operand_scoreboard.sv | 142 ++++++++++++++
 tb/tb_cmov_operand_scoreboard.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cmov_pkg.sv
// cmov_pkg
// Shared definitions for the conditional-move operand scoreboard:
//   - FWD_* forwarding-select encodings
//   - REG_W register-index width
//   - entry_t: one tracked in-flight instruction
//   - cmov_write(): MOVZ/MOVN write resolution, the same rule the MEM-stage
//     register-file write enable uses
package cmov_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic             regwrite;
        logic             condmov;
        logic             resolved_write;
    } entry_t;

    // Unconditional writers always write; a conditional move writes only
    // when the zero flag of its condition is set.
    function automatic logic cmov_write(input logic regwrite,
                                        input logic condmov,
                                        input logic zero);
        return (regwrite & ~condmov) | (condmov & zero);
    endfunction

endpackage

// File: rtl/cmov_fwd_select.sv
// cmov_fwd_select
// Per-source forwarding priority mux. MEM beats WB; register 0 never forwards.
// Ports:
//   i_src      source register index
//   i_mem_en   MEM entry is a producer this cycle (valid and write resolved)
//   i_mem_wreg MEM entry destination
//   i_wb_en    WB entry is a producer (valid and resolved_write)
//   i_wb_wreg  WB entry destination
//   o_fwd      FWD_REGFILE / FWD_MEM / FWD_WB
module cmov_fwd_select
    import cmov_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_mem_en,
    input  logic [REG_W-1:0] i_mem_wreg,
    input  logic             i_wb_en,
    input  logic [REG_W-1:0] i_wb_wreg,
    output logic [1:0]       o_fwd
);

    logic w_src_ok;
    assign w_src_ok = (i_src != '0);

    always_comb begin
        o_fwd = FWD_REGFILE;
        // A not-taken cmov in MEM has i_mem_en low, so the WB check still applies.
        if (w_src_ok && i_mem_en && (i_mem_wreg == i_src))
            o_fwd = FWD_MEM;
        else if (w_src_ok && i_wb_en && (i_wb_wreg == i_src))
            o_fwd = FWD_WB;
    end

endmodule

// File: rtl/cmov_operand_scoreboard.sv
// cmov_operand_scoreboard
// ID-stage scoreboard tracking destinations in EX/MEM/WB, resolving
// MOVZ/MOVN writes, and telling ID to stall or forward each source.
// Optional feature macro: CMOV_STALL_COUNT_EN adds a saturating 32-bit
// StallCount output counting cycles with Stall=1.
// Ports:
//   Clk, Rst                      clock (rising), async active-high reset
//   ID_Issue/RegWrite/CondMov     issuing instruction control
//   ID_WriteReg                   issuing instruction destination
//   ID_Rs/ID_Rt, ID_UseRs/UseRt   sources and their use flags
//   MEM_Zero                      zero flag of the MEM instruction
//   Flush                         squash the incoming EX entry
//   Stall                         hold ID/IF, bubble into EX (combinational)
//   ForwardA/ForwardB             00 regfile, 01 MEM, 10 WB
//   WB_Write                      registered WB register-file write enable
//   StallCount                    (CMOV_STALL_COUNT_EN only)
module cmov_operand_scoreboard
    import cmov_pkg::*;
#(
    parameter int REG_W    = cmov_pkg::REG_W,
    parameter int NUM_REGS = 32
)
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ID_Issue,
    input  logic             ID_RegWrite,
    input  logic             ID_CondMov,
    input  logic [REG_W-1:0] ID_WriteReg,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             MEM_Zero,
    input  logic             Flush,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             WB_Write
`ifdef CMOV_STALL_COUNT_EN
    ,
    output logic [31:0]      StallCount
`endif
);

    localparam logic [REG_W:0] LP_NREGS = NUM_REGS[REG_W:0];

    // Index 0 is hard-wired zero; indices beyond the register file never match.
    function automatic logic idx_ok(input logic [REG_W-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < LP_NREGS);
    endfunction

    entry_t r_ex, r_mem, r_wb;
    logic   r_wb_write;

    entry_t w_ex_next, w_mem_out;
    logic   w_load, w_mem_res, w_ex_pw, w_hit_a, w_hit_b;
    logic   w_mem_en, w_wb_en;

    // ---------------- stall ----------------
    assign w_ex_pw = r_ex.valid & (r_ex.regwrite | r_ex.condmov) & (r_ex.wreg != '0);
    assign w_hit_a = ID_UseRs & idx_ok(ID_Rs) & w_ex_pw & (ID_Rs == r_ex.wreg);
    assign w_hit_b = ID_UseRt & idx_ok(ID_Rt) & w_ex_pw & (ID_Rt == r_ex.wreg);
    assign Stall   = w_hit_a | w_hit_b;

    // ---------------- next entries ----------------
    // A stalled issue is dropped here; ID re-presents it next cycle.
    assign w_load    = ID_Issue & ~Stall & ~Flush;
    assign w_mem_res = cmov_write(r_mem.regwrite, r_mem.condmov, MEM_Zero);

    always_comb begin
        w_ex_next = '0;
        if (w_load) begin
            w_ex_next.valid    = 1'b1;
            w_ex_next.wreg     = ID_WriteReg;
            w_ex_next.regwrite = ID_RegWrite;
            w_ex_next.condmov  = ID_CondMov;
        end
    end

    always_comb begin
        w_mem_out                = r_mem;
        w_mem_out.resolved_write = w_mem_res;
    end

    // ---------------- pipeline ----------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_wb_write <= 1'b0;
        end else begin
            r_ex       <= w_ex_next;
            r_mem      <= r_ex;
            r_wb       <= w_mem_out;
            r_wb_write <= r_mem.valid & w_mem_res & (r_mem.wreg != '0);
        end
    end

    assign WB_Write = r_wb_write;

    // ---------------- forwarding ----------------
    assign w_mem_en = r_mem.valid & w_mem_res;
    assign w_wb_en  = r_wb.valid & r_wb.resolved_write;

    cmov_fwd_select u_fwd_a (
        .i_src      (ID_Rs),
        .i_mem_en   (w_mem_en),
        .i_mem_wreg (r_mem.wreg),
        .i_wb_en    (w_wb_en),
        .i_wb_wreg  (r_wb.wreg),
        .o_fwd      (ForwardA)
    );

    cmov_fwd_select u_fwd_b (
        .i_src      (ID_Rt),
        .i_mem_en   (w_mem_en),
        .i_mem_wreg (r_mem.wreg),
        .i_wb_en    (w_wb_en),
        .i_wb_wreg  (r_wb.wreg),
        .o_fwd      (ForwardB)
    );

    // Entry fields kept for debug visibility but not consumed by any logic.
    logic w_unused_fields;
    assign w_unused_fields = ^{r_mem.resolved_write, r_wb.regwrite, r_wb.condmov};

`ifdef CMOV_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_stall_count <= '0;
        else if (Stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_cmov_operand_scoreboard.sv
module tb_cmov_operand_scoreboard;
    import cmov_pkg::*;

    logic             Clk, Rst;
    logic             ID_Issue, ID_RegWrite, ID_CondMov;
    logic [4:0]       ID_WriteReg, ID_Rs, ID_Rt;
    logic             ID_UseRs, ID_UseRt, MEM_Zero, Flush;
    logic             Stall, WB_Write;
    logic [1:0]       ForwardA, ForwardB;
`ifdef CMOV_STALL_COUNT_EN
    logic [31:0]      StallCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cmov_operand_scoreboard dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ID_Issue    (ID_Issue),
        .ID_RegWrite (ID_RegWrite),
        .ID_CondMov  (ID_CondMov),
        .ID_WriteReg (ID_WriteReg),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UseRs    (ID_UseRs),
        .ID_UseRt    (ID_UseRt),
        .MEM_Zero    (MEM_Zero),
        .Flush       (Flush),
        .Stall       (Stall),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .WB_Write    (WB_Write)
`ifdef CMOV_STALL_COUNT_EN
        ,
        .StallCount  (StallCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic iss, input logic rw, input logic cm, input logic [4:0] wr,
                          input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
        ID_Issue = iss; ID_RegWrite = rw; ID_CondMov = cm; ID_WriteReg = wr;
        ID_Rs = rs; ID_UseRs = urs; ID_Rt = rt; ID_UseRt = urt;
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        MEM_Zero = 1'b0; Flush = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        Rst = 1'b1; MEM_Zero = 1'b0; Flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        step();
        chk("rst_stall", Stall, 0);
        chk("rst_fwda", ForwardA, 0);
        chk("rst_fwdb", ForwardB, 0);
        chk("rst_wbw", WB_Write, 0);
        Rst = 1'b0;
        step();

        // plain RAW: ADD -> $5, then reader of $5 held in ID
        set_id(1, 1, 0, 5, 0, 0, 0, 0);
        step();
        set_id(1, 0, 0, 0, 5, 1, 0, 0);
        chk("raw_stall", Stall, 1);
        step();
        chk("raw_stall_1cyc", Stall, 0);
        chk("raw_fwd_mem", ForwardA, FWD_MEM);
        step();
        chk("raw_fwd_wb", ForwardA, FWD_WB);
        chk("raw_wbw", WB_Write, 1);
        drain();

        // MOVZ -> $7 taken
        set_id(1, 0, 1, 7, 0, 0, 0, 0);
        step();
        set_id(1, 0, 0, 0, 0, 0, 7, 1);
        chk("cm_stall", Stall, 1);
        step();
        MEM_Zero = 1'b1; #1;
        chk("cm_nostall", Stall, 0);
        chk("cm_fwd_mem", ForwardB, FWD_MEM);
        chk("cm_wbw_pre", WB_Write, 0);
        step();
        chk("cm_wbw", WB_Write, 1);
        chk("cm_fwd_wb", ForwardB, FWD_WB);
        drain();

        // ADD -> $7, then MOVZ -> $7 not taken: falls through to WB
        set_id(1, 1, 0, 7, 0, 0, 0, 0);
        step();
        set_id(1, 0, 1, 7, 0, 0, 0, 0);
        step();
        set_id(1, 0, 0, 0, 0, 0, 7, 1);
        chk("nt_stall", Stall, 1);
        step();
        chk("nt_fallthru_wb", ForwardB, FWD_WB);
        MEM_Zero = 1'b1; #1;
        chk("nt_zero_flip_mem", ForwardB, FWD_MEM);
        MEM_Zero = 1'b0; #1;
        step();
        chk("nt_wbw", WB_Write, 0);
        chk("nt_fwd_none", ForwardB, FWD_REGFILE);
        drain();

        // priority and $0: WB=$3, MEM=$3, EX=$0
        set_id(1, 1, 0, 3, 0, 0, 0, 0);
        step();
        step();
        set_id(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        set_id(0, 0, 0, 0, 3, 1, 0, 1);
        chk("pri_fwda", ForwardA, FWD_MEM);
        chk("pri_fwdb_r0", ForwardB, FWD_REGFILE);
        chk("pri_stall_r0", Stall, 0);
        chk("pri_wbw", WB_Write, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("r0_wbw", WB_Write, 0);
        drain();

        // flush: issued writer squashed
        Flush = 1'b1;
        set_id(1, 1, 0, 9, 0, 0, 0, 0);
        step();
        Flush = 1'b0;
        set_id(1, 0, 0, 0, 9, 1, 0, 0);
        chk("flush_nostall", Stall, 0);
        step();
        chk("flush_nofwd", ForwardA, FWD_REGFILE);
        drain();

        // asynchronous reset with entries loaded
        set_id(1, 1, 0, 9, 0, 0, 0, 0);
        step();
        set_id(1, 1, 0, 10, 0, 0, 0, 0);
        step();
        set_id(0, 0, 0, 0, 10, 1, 0, 0);
        step();
        chk("pre_rst_fwda", ForwardA, FWD_MEM);
        chk("pre_rst_wbw", WB_Write, 1);
        #2 Rst = 1'b1; #1;
        chk("async_rst_fwda", ForwardA, FWD_REGFILE);
        chk("async_rst_wbw", WB_Write, 0);
        chk("async_rst_stall", Stall, 0);
        Rst = 1'b0;
        step();
        chk("post_rst_fwda", ForwardA, FWD_REGFILE);

        // self-dependent ADD $11,$11 re-presented: stalls on every other edge
        set_id(1, 1, 0, 11, 11, 1, 0, 0);
        chk("cnt_nostall0", Stall, 0);
        step();
        chk("cnt_stall1", Stall, 1);
        repeat (5) step();
`ifdef CMOV_STALL_COUNT_EN
        chk("stall_count", StallCount, 3);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
